// File: rtl/mac_vec_if.sv
// Operand/result stream bundle for mac_vec_engine: valid/ready beat input,
// valid/ready held result output, plus clear, beat count and overflow flags.
interface mac_vec_if #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int LANES   = 4,
  parameter int VEC_LEN = 8
);
  localparam int CNT_W = $clog2(VEC_LEN + 1);

  logic                     clr;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*DATA_W-1:0]  a_in;
  logic [DATA_W-1:0]        b_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*ACC_W-1:0]   c_out;
  logic [CNT_W-1:0]         beat_cnt;
  logic [LANES-1:0]         ovf;

  modport master (
    output clr, in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, c_out, beat_cnt, ovf
  );

  modport slave (
    input  clr, in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, c_out, beat_cnt, ovf
  );
endinterface

// File: rtl/mac_vec_engine.sv
// Multi-lane dot-product MAC: LANES accumulators share a broadcast B operand over VEC_LEN beats.
// Define MAC_SAT_EN to make each lane add saturate and set a sticky per-lane ovf flag.
module mac_vec_engine #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int LANES   = 4,
  parameter int VEC_LEN = 8,
  parameter int SIGNED  = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  mac_vec_if.slave bus
);
  localparam int CNT_W  = $clog2(VEC_LEN + 1);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t           state, state_next;
  logic             accept;
  logic             last_beat;
  logic             res_taken;
  logic             s1_valid;
  logic [CNT_W-1:0] beat_cnt;
  logic [ACC_W-1:0] s1_prod  [LANES];
  logic [ACC_W-1:0] acc      [LANES];
  logic [ACC_W-1:0] acc_next [LANES];

  // Full product fits in PROD_W bits for both signednesses, so only the low bits are formed.
  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [PROD_W-1:0] ax, bx, p;
    if (SIGNED != 0) begin
      ax = PROD_W'(signed'(a));
      bx = PROD_W'(signed'(b));
    end else begin
      ax = PROD_W'(a);
      bx = PROD_W'(b);
    end
    p = ax * bx;
    if (SIGNED != 0) return ACC_W'(signed'(p));
    else             return ACC_W'(p);
  endfunction

  assign accept    = bus.in_valid & bus.in_ready;
  assign last_beat = accept && (beat_cnt == CNT_W'(VEC_LEN - 1));
  assign res_taken = (state == HOLD) & bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) state <= ACCUM;
    else                   state <= state_next;
  end

  // NOTE: each combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (last_beat) state_next = DRAIN;
      DRAIN:   state_next = HOLD;
      HOLD:    if (bus.out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    bus.in_ready  = rst_n & ~bus.clr & (state == ACCUM);
    bus.out_valid = (state == HOLD);
  end

  // NOTE: the product pipeline is pure datapath qualified by s1_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < LANES; i++)
        s1_prod[i] <= mul_ext(bus.a_in[i*DATA_W +: DATA_W], bus.b_in);
    end
  end

`ifdef MAC_SAT_EN
  logic [LANES-1:0] clamp;
  logic [LANES-1:0] ovf;

  always_comb begin
    clamp = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_next[i] = acc[i] + s1_prod[i];
      if (SIGNED != 0) begin
        // Overflow only when both addends share a sign and the sum flips it.
        if ((acc[i][ACC_W-1] == s1_prod[i][ACC_W-1]) &&
            (acc_next[i][ACC_W-1] != acc[i][ACC_W-1])) begin
          clamp[i]    = 1'b1;
          acc_next[i] = acc[i][ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        end
      end else if (acc_next[i] < acc[i]) begin
        clamp[i]    = 1'b1;
        acc_next[i] = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr || res_taken) ovf <= '0;
    else if (s1_valid)                  ovf <= ovf | clamp;
  end

  assign bus.ovf = ovf;
`else
  always_comb begin
    for (int i = 0; i < LANES; i++) acc_next[i] = acc[i] + s1_prod[i];
  end

  assign bus.ovf = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      s1_valid <= 1'b0;
      beat_cnt <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (res_taken) begin
        beat_cnt <= '0;
        for (int i = 0; i < LANES; i++) acc[i] <= '0;
      end else begin
        if (accept)   beat_cnt <= beat_cnt + CNT_W'(1);
        if (s1_valid) begin
          for (int i = 0; i < LANES; i++) acc[i] <= acc_next[i];
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane_out
    assign bus.c_out[g*ACC_W +: ACC_W] = acc[g];
  end

  assign bus.beat_cnt = beat_cnt;
endmodule

// File: tb/tb_mac_vec_engine.sv
// Self-checking bench for mac_vec_engine: three configurations (unsigned 24-bit, unsigned 16-bit,
// signed single-beat) driven by a vector table, hand sequences and a random dot-product model.
module tb_mac_vec_engine;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  mac_vec_if #(.DATA_W(8), .ACC_W(24), .LANES(4), .VEC_LEN(2)) m0 ();
  mac_vec_if #(.DATA_W(8), .ACC_W(16), .LANES(4), .VEC_LEN(2)) m1 ();
  mac_vec_if #(.DATA_W(8), .ACC_W(24), .LANES(4), .VEC_LEN(1)) m2 ();

  mac_vec_engine #(.DATA_W(8), .ACC_W(24), .LANES(4), .VEC_LEN(2), .SIGNED(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(m0));
  mac_vec_engine #(.DATA_W(8), .ACC_W(16), .LANES(4), .VEC_LEN(2), .SIGNED(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(m1));
  mac_vec_engine #(.DATA_W(8), .ACC_W(24), .LANES(4), .VEC_LEN(1), .SIGNED(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(m2));

  // Packed lane arrays: element [0] is lane 0 in the low bits, matching the bus layout.
  typedef struct packed {
    logic [3:0][7:0]  a0;
    logic [7:0]       b0;
    logic [3:0][7:0]  a1;
    logic [7:0]       b1;
    logic [3:0][23:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Two-beat unsigned dot product per lane, modulo 2^24.
  function automatic logic [95:0] model(input logic [31:0] a0, input logic [7:0] b0,
                                        input logic [31:0] a1, input logic [7:0] b1);
    logic [95:0] r;
    longint s;
    for (int i = 0; i < 4; i++) begin
      s = longint'(a0[i*8 +: 8]) * longint'(b0) + longint'(a1[i*8 +: 8]) * longint'(b1);
      r[i*24 +: 24] = 24'(s % 64'd16777216);
    end
    return r;
  endfunction

  // One full vector on dut0, then release either via out_ready or via clr while holding.
  task automatic run_vec0(input logic [31:0] a0, input logic [7:0] b0,
                          input logic [31:0] a1, input logic [7:0] b1,
                          input int gap, input int hold, input bit clr_in_hold,
                          input logic [95:0] exp, input string tag);
    @(posedge clk); #1;
    repeat (gap) begin m0.in_valid = 1'b0; @(posedge clk); #1; end
    m0.in_valid = 1'b1; m0.a_in = a0; m0.b_in = b0;
    @(negedge clk); check({tag, ".rdy0"}, m0.in_ready, 1);
    @(posedge clk); #1;
    repeat (gap) begin m0.in_valid = 1'b0; @(posedge clk); #1; end
    m0.in_valid = 1'b1; m0.a_in = a1; m0.b_in = b1;
    @(negedge clk);
    check({tag, ".rdy1"}, m0.in_ready, 1);
    check({tag, ".cnt1"}, m0.beat_cnt, 1);
    @(posedge clk); #1;
    // Keep offering junk: it must not be taken in DRAIN or HOLD.
    m0.a_in = ~a1; m0.b_in = 8'hFF;
    @(negedge clk);
    check({tag, ".drain_valid"}, m0.out_valid, 0);
    check({tag, ".drain_rdy"}, m0.in_ready, 0);
    check({tag, ".drain_cnt"}, m0.beat_cnt, 2);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, ".valid"}, m0.out_valid, 1);
    check({tag, ".result"}, m0.c_out, exp);
    repeat (hold) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, ".stable"}, m0.c_out, exp);
      check({tag, ".hold_rdy"}, m0.in_ready, 0);
      check({tag, ".hold_cnt"}, m0.beat_cnt, 2);
    end
    if (clr_in_hold) m0.clr = 1'b1;
    else             m0.out_ready = 1'b1;
    @(posedge clk); #1;
    m0.clr = 1'b0; m0.out_ready = 1'b0; m0.in_valid = 1'b0;
    @(negedge clk);
    check({tag, ".rel_valid"}, m0.out_valid, 0);
    check({tag, ".rel_cout"}, m0.c_out, 0);
    check({tag, ".rel_cnt"}, m0.beat_cnt, 0);
    check({tag, ".rel_rdy"}, m0.in_ready, 1);
  endtask

  // Single-beat signed vector on dut2.
  task automatic run_vec2(input logic [31:0] a, input logic [7:0] b,
                          input logic [95:0] exp, input string tag);
    @(posedge clk); #1;
    m2.in_valid = 1'b1; m2.a_in = a; m2.b_in = b;
    @(negedge clk); check({tag, ".rdy"}, m2.in_ready, 1);
    @(posedge clk); #1;
    m2.in_valid = 1'b0;
    @(negedge clk);
    check({tag, ".drain_valid"}, m2.out_valid, 0);
    check({tag, ".cnt"}, m2.beat_cnt, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, ".valid"}, m2.out_valid, 1);
    check({tag, ".result"}, m2.c_out, exp);
    m2.out_ready = 1'b1;
    @(posedge clk); #1;
    m2.out_ready = 1'b0;
    @(negedge clk); check({tag, ".rel_valid"}, m2.out_valid, 0);
  endtask

  initial begin
    vec_t tbl[5];
    logic [31:0] ra0, ra1;
    logic [7:0]  rb0, rb1;

    // Lane 3 is written first in each concatenation.
    tbl[0] = '{a0: {8'd4, 8'd3, 8'd2, 8'd1}, b0: 8'd3,
               a1: {8'd10, 8'd10, 8'd10, 8'd10}, b1: 8'd5,
               exp: {24'd62, 24'd59, 24'd56, 24'd53}};
    tbl[1] = '{a0: {4{8'd255}}, b0: 8'd255, a1: {4{8'd255}}, b1: 8'd255,
               exp: {4{24'd130050}}};
    tbl[2] = '{a0: {8'd1, 8'd100, 8'd0, 8'd7}, b0: 8'd2,
               a1: {8'd200, 8'd0, 8'd9, 8'd1}, b1: 8'd0,
               exp: {24'd2, 24'd200, 24'd0, 24'd14}};
    tbl[3] = '{a0: {8'd128, 8'd64, 8'd32, 8'd16}, b0: 8'd128,
               a1: {4{8'd1}}, b1: 8'd1,
               exp: {24'd16385, 24'd8193, 24'd4097, 24'd2049}};
    tbl[4] = '{a0: '0, b0: 8'd0, a1: '0, b1: 8'd0, exp: '0};

    {m0.clr, m0.in_valid, m0.out_ready, m0.a_in, m0.b_in} = '0;
    {m1.clr, m1.in_valid, m1.out_ready, m1.a_in, m1.b_in} = '0;
    {m2.clr, m2.in_valid, m2.out_ready, m2.a_in, m2.b_in} = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.cout", m0.c_out, 0);
    check("rst.valid", m0.out_valid, 0);
    check("rst.cnt", m0.beat_cnt, 0);
    check("rst.rdy", m0.in_ready, 0);
    check("rst.ovf", m0.ovf, 0);
    rst_n = 1'b1;
    #1;
    check("rst.release_rdy", m0.in_ready, 1);

    // Table vectors, varying gaps and hold time
    for (int i = 0; i < 5; i++)
      run_vec0(tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, i % 3, (i == 0) ? 5 : i % 2,
               1'b0, tbl[i].exp, $sformatf("tbl%0d", i));

    // clr after one accepted beat, with a beat offered in the clr cycle
    @(posedge clk); #1;
    m0.in_valid = 1'b1; m0.a_in = 32'h01010101; m0.b_in = 8'd9;
    @(posedge clk); #1;
    m0.clr = 1'b1; m0.a_in = 32'h05050505;
    @(negedge clk);
    check("clr.rdy", m0.in_ready, 0);
    check("clr.cnt_pre", m0.beat_cnt, 1);
    @(posedge clk); #1;
    m0.clr = 1'b0; m0.in_valid = 1'b0;
    @(negedge clk);
    check("clr.cnt", m0.beat_cnt, 0);
    check("clr.cout", m0.c_out, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("clr.cout_late", m0.c_out, 0);
    check("clr.cnt_late", m0.beat_cnt, 0);
    run_vec0(tbl[0].a0, tbl[0].b0, tbl[0].a1, tbl[0].b1, 0, 1, 1'b1, tbl[0].exp, "clr_fresh");
    run_vec0(tbl[3].a0, tbl[3].b0, tbl[3].a1, tbl[3].b1, 0, 0, 1'b0, tbl[3].exp, "post_clr");

    // Reset mid-vector discards the partial result
    @(posedge clk); #1;
    m0.in_valid = 1'b1; m0.a_in = 32'h11111111; m0.b_in = 8'd7;
    @(posedge clk); #1;
    rst_n = 1'b0; m0.in_valid = 1'b0;
    @(negedge clk); check("mrst.rdy", m0.in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst.cnt", m0.beat_cnt, 0);
    check("mrst.cout", m0.c_out, 0);
    run_vec0(tbl[2].a0, tbl[2].b0, tbl[2].a1, tbl[2].b1, 1, 0, 1'b0, tbl[2].exp, "mrst_fresh");

    // Randomized vectors against the dot-product model
    for (int n = 0; n < 20; n++) begin
      ra0 = $urandom; ra1 = $urandom;
      rb0 = 8'($urandom_range(0, 255)); rb1 = 8'($urandom_range(0, 255));
      run_vec0(ra0, rb0, ra1, rb1, $urandom_range(0, 2), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0), model(ra0, rb0, ra1, rb1), $sformatf("rnd%0d", n));
    end

    // 16-bit accumulator overflow: wrap, or clamp with sticky ovf
    @(posedge clk); #1;
    m1.in_valid = 1'b1; m1.a_in = 32'hFFFFFFFF; m1.b_in = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m1.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("ovf16.valid", m1.out_valid, 1);
`ifdef MAC_SAT_EN
    check("ovf16.cout", m1.c_out, {4{16'hFFFF}});
    check("ovf16.flag", m1.ovf, 4'hF);
`else
    check("ovf16.cout", m1.c_out, {4{16'd64514}});
    check("ovf16.flag", m1.ovf, 4'h0);
`endif
    m1.out_ready = 1'b1;
    @(posedge clk); #1;
    m1.out_ready = 1'b0;
    @(negedge clk);
    check("ovf16.flag_clr", m1.ovf, 0);
    check("ovf16.cout_clr", m1.c_out, 0);

    // Signed single-beat vectors
    run_vec2({4{8'hFD}}, 8'd7, {4{24'hFFFFEB}}, "sgn_neg");
    run_vec2({4{8'h80}}, 8'h80, {4{24'h004000}}, "sgn_minmin");
    run_vec2({8'hFF, 8'h01, 8'h80, 8'h7F}, 8'h80,
             {24'h000080, 24'hFFFF80, 24'h004000, 24'hFFC080}, "sgn_mixed");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit");
  end
endmodule
